// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for the trap/interrupt controller: instruction opcodes,
// FSM states, default widths and the mcause helper.
package irq_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_RDATA_WIDTH = 32;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  localparam int MCAUSE_INT_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_JUMP = 2'd2
  } irq_state_e;

  // Interrupt mcause: exception code with the interrupt flag on top.
  function automatic logic [31:0] irq_cause(input int unsigned code);
    logic [31:0] c;
    c                 = 32'(code);
    c[MCAUSE_INT_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Decode-side / CSR-side bundle of the trap controller.
// master = core (decode, CSR file, PC mux), slave = irq_ctrl.
interface irq_ctrl_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RDATA_WIDTH = 32,
  parameter int NUM_IRQ     = 4
);

  logic [RDATA_WIDTH-1:0] inst_i;
  logic [ADDR_WIDTH-1:0]  inst_addr_i;
  logic                   inst_valid_i;
  logic [NUM_IRQ-1:0]     irq_i;
  logic [NUM_IRQ-1:0]     irq_mask_i;
  logic                   mie_global_i;
  logic [ADDR_WIDTH-1:0]  mtvec_i;
  logic [ADDR_WIDTH-1:0]  mepc_i;

  logic                   hold_o;
  logic                   interrupt_enable_o;
  logic [ADDR_WIDTH-1:0]  int_addr_o;
  logic                   csr_we_o;
  logic [ADDR_WIDTH-1:0]  mepc_o;
  logic [31:0]            mcause_o;
  logic                   mret_o;

  modport master (
    output inst_i, inst_addr_i, inst_valid_i, irq_i, irq_mask_i,
           mie_global_i, mtvec_i, mepc_i,
    input  hold_o, interrupt_enable_o, int_addr_o, csr_we_o,
           mepc_o, mcause_o, mret_o
  );

  modport slave (
    input  inst_i, inst_addr_i, inst_valid_i, irq_i, irq_mask_i,
           mie_global_i, mtvec_i, mepc_i,
    output hold_o, interrupt_enable_o, int_addr_o, csr_we_o,
           mepc_o, mcause_o, mret_o
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder for the enabled irq set.
module irq_prio_enc #(
  parameter  int NUM_IRQ = 4,
  localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Registered trap/interrupt controller: ECALL, MRET and NUM_IRQ masked lines,
// sequenced IDLE -> SAVE (CSR write) -> JUMP (redirect).
// Optional IRQ_VECTORED_EN: mtvec mode 01 vectors interrupts to base + 4*cause.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int RDATA_WIDTH    = DEF_RDATA_WIDTH,
  parameter int NUM_IRQ        = 4,
  parameter int ECALL_CAUSE    = 11,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input logic       clk_i,
  input logic       rst_i,
  irq_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

`ifdef IRQ_VECTORED_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  irq_state_e            state;
  logic [NUM_IRQ-1:0]    pending;
  logic [NUM_IRQ-1:0]    pending_clr;
  logic [NUM_IRQ-1:0]    irq_en;
  logic                  irq_found;
  logic [IDX_W-1:0]      irq_idx;
  logic [IDX_W-1:0]      irq_idx_q;
  logic                  is_ecall;
  logic                  is_mret;
  logic                  hold_q;
  logic                  redirect_q;
  logic                  csr_we_q;
  logic [ADDR_WIDTH-1:0] tgt_q;
  logic [ADDR_WIDTH-1:0] mepc_q;
  logic [31:0]           mcause_q;
  logic [ADDR_WIDTH-1:0] trap_tgt;

  assign is_ecall = bus.inst_valid_i && (bus.inst_i == RDATA_WIDTH'(INST_ECALL));
  assign is_mret  = bus.inst_valid_i && (bus.inst_i == RDATA_WIDTH'(INST_MRET));
  assign irq_en   = pending & bus.irq_mask_i & {NUM_IRQ{bus.mie_global_i}};

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (irq_en),
    .found (irq_found),
    .idx   (irq_idx)
  );

  // Only an interrupt SAVE retires its pending bit; ECALL leaves pending alone.
  always_comb begin
    pending_clr = '0;
    if (state == ST_SAVE && mcause_q[MCAUSE_INT_BIT])
      pending_clr[irq_idx_q] = 1'b1;
  end

  always_comb begin
    trap_tgt = {bus.mtvec_i[ADDR_WIDTH-1:2], 2'b00};
    if (VECTORED && bus.mtvec_i[1:0] == 2'b01 && mcause_q[MCAUSE_INT_BIT])
      trap_tgt = trap_tgt + ADDR_WIDTH'((IRQ_CAUSE_BASE + int'(irq_idx_q)) * 4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      pending    <= '0;
      hold_q     <= 1'b0;
      redirect_q <= 1'b0;
      csr_we_q   <= 1'b0;
      tgt_q      <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      irq_idx_q  <= '0;
    end else begin
      pending <= (pending & ~pending_clr) | bus.irq_i;
      case (state)
        ST_IDLE: begin
          if (is_ecall) begin
            state    <= ST_SAVE;
            hold_q   <= 1'b1;
            csr_we_q <= 1'b1;
            mepc_q   <= bus.inst_addr_i;
            mcause_q <= 32'(ECALL_CAUSE);
          end else if (is_mret) begin
            state      <= ST_JUMP;
            hold_q     <= 1'b1;
            redirect_q <= 1'b1;
            tgt_q      <= bus.mepc_i;
          end else if (irq_found) begin
            state     <= ST_SAVE;
            hold_q    <= 1'b1;
            csr_we_q  <= 1'b1;
            mepc_q    <= bus.inst_addr_i;
            mcause_q  <= irq_cause(IRQ_CAUSE_BASE + int'(irq_idx));
            irq_idx_q <= irq_idx;
          end
        end
        ST_SAVE: begin
          state      <= ST_JUMP;
          csr_we_q   <= 1'b0;
          redirect_q <= 1'b1;
          tgt_q      <= trap_tgt;
        end
        ST_JUMP: begin
          state      <= ST_IDLE;
          hold_q     <= 1'b0;
          redirect_q <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          hold_q     <= 1'b0;
          redirect_q <= 1'b0;
          csr_we_q   <= 1'b0;
        end
      endcase
    end
  end

  // mret_o is the one combinational output: the CSR restores MIE in the same
  // cycle MRET is decoded so the redirect lands one cycle later.
  assign bus.mret_o             = !rst_i && (state == ST_IDLE) && is_mret && !is_ecall;
  assign bus.hold_o             = hold_q;
  assign bus.interrupt_enable_o = redirect_q;
  assign bus.int_addr_o         = tgt_q;
  assign bus.csr_we_o           = csr_we_q;
  assign bus.mepc_o             = mepc_q;
  assign bus.mcause_o           = mcause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios then random traffic,
// all scored against a per-cycle event-schedule reference model.
module tb_irq_ctrl;

  localparam int AW = 32;
  localparam int RW = 32;
  localparam int NI = 4;
  localparam int EC = 11;
  localparam int CB = 16;
  localparam logic [31:0] OP_ECALL = 32'h0000_0073;
  localparam logic [31:0] OP_MRET  = 32'h3020_0073;
  localparam logic [31:0] OP_NOP   = 32'h0000_0013;
`ifdef IRQ_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  irq_ctrl_if #(.ADDR_WIDTH(AW), .RDATA_WIDTH(RW), .NUM_IRQ(NI)) bus ();

  irq_ctrl #(
    .ADDR_WIDTH(AW), .RDATA_WIDTH(RW), .NUM_IRQ(NI),
    .ECALL_CAUSE(EC), .IRQ_CAUSE_BASE(CB)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a schedule of future output events per cycle number.
  typedef struct {
    int          cyc;
    bit          is_save;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] addr;
    bit          is_irq;
    int          idx;
  } ev_t;

  ev_t         ev_q[$];
  logic [NI-1:0] m_pend = '0;
  logic [31:0] m_mepc = '0, m_mcause = '0, m_addr = '0;
  int          cyc = 0;
  bit          chk_en = 1'b0;

  logic [NI-1:0] d_mask  = '1;
  logic          d_mie   = 1'b1;
  logic [31:0]   d_mtvec = 32'h100;
  logic [31:0]   d_mepc  = 32'h44;

  function automatic logic [31:0] tgt(input logic [31:0] mtvec, input bit is_irq, input int idx);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (VEC && is_irq && mtvec[1:0] == 2'b01) return base + 32'((CB + idx) * 4);
    return base;
  endfunction

  task automatic step(input logic rst, input logic vld, input logic [31:0] inst,
                      input logic [31:0] addr, input logic [NI-1:0] irq);
    ev_t cur, e;
    bit have, found;
    logic [NI-1:0] en, clr;
    int k;
    @(negedge clk_i);
    rst_i            = rst;
    bus.inst_valid_i = vld;
    bus.inst_i       = inst;
    bus.inst_addr_i  = addr;
    bus.irq_i        = irq;
    bus.irq_mask_i   = d_mask;
    bus.mie_global_i = d_mie;
    bus.mtvec_i      = d_mtvec;
    bus.mepc_i       = d_mepc;
    #1;
    have = 1'b0;
    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
      cur  = ev_q.pop_front();
      have = 1'b1;
      if (cur.is_save) begin m_mepc = cur.mepc; m_mcause = cur.mcause; end
      else m_addr = cur.addr;
    end
    if (chk_en) begin
      chk("hold",     32'(bus.hold_o),             32'(have));
      chk("csr_we",   32'(bus.csr_we_o),           32'(have && cur.is_save));
      chk("irq_en",   32'(bus.interrupt_enable_o), 32'(have && !cur.is_save));
      chk("mret",     32'(bus.mret_o),             32'(!have && !rst && vld && inst == OP_MRET));
      chk("mepc",     bus.mepc_o,     m_mepc);
      chk("mcause",   bus.mcause_o,   m_mcause);
      chk("int_addr", bus.int_addr_o, m_addr);
    end
    if (rst) begin
      ev_q.delete();
      m_pend = '0; m_mepc = '0; m_mcause = '0; m_addr = '0;
    end else begin
      clr = '0;
      e   = '{cyc: cyc + 1, is_save: 1'b0, mepc: '0, mcause: '0, addr: '0, is_irq: 1'b0, idx: 0};
      if (have && cur.is_save) begin
        if (cur.is_irq) clr[cur.idx] = 1'b1;
        e.addr = tgt(d_mtvec, cur.is_irq, cur.idx);
        ev_q.push_back(e);
      end else if (!have) begin
        en    = m_pend & d_mask & {NI{d_mie}};
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NI; i++)
          if (en[i] && !found) begin found = 1'b1; k = i; end
        if (vld && inst == OP_ECALL) begin
          e.is_save = 1'b1; e.mepc = addr; e.mcause = 32'(EC);
          ev_q.push_back(e);
        end else if (vld && inst == OP_MRET) begin
          e.addr = d_mepc;
          ev_q.push_back(e);
        end else if (found) begin
          e.is_save = 1'b1; e.mepc = addr; e.mcause = 32'h8000_0000 | 32'(CB + k);
          e.is_irq = 1'b1; e.idx = k;
          ev_q.push_back(e);
        end
      end
      m_pend = (m_pend & ~clr) | irq;
    end
    @(posedge clk_i);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, OP_NOP, 32'h0, '0);
  endtask

  logic [31:0] r_mtvec, r_inst;
  logic [NI-1:0] r_irq;
  int sel;

  initial begin
    // Reset held 3 cycles with every irq line high.
    step(1'b1, 1'b0, OP_NOP, 32'h0, 4'hF);
    chk_en = 1'b1;
    step(1'b1, 1'b0, OP_NOP, 32'h0, 4'hF);
    step(1'b1, 1'b0, OP_NOP, 32'h0, 4'hF);
    idle(3);
    #1 chk("rst_no_trap", 32'(bus.hold_o), 32'h0);

    // ECALL at 0x40, mtvec 0x100.
    step(1'b0, 1'b1, OP_ECALL, 32'h40, '0);
    #1 chk("ecall_we", 32'(bus.csr_we_o), 32'h1);
    chk("ecall_mepc", bus.mepc_o, 32'h40);
    chk("ecall_cause", bus.mcause_o, 32'd11);
    d_mie = 1'b0;
    step(1'b0, 1'b0, OP_NOP, 32'h44, '0);
    #1 chk("ecall_redir", 32'(bus.interrupt_enable_o), 32'h1);
    chk("ecall_tgt", bus.int_addr_o, 32'h100);
    idle(1);
    // MRET back to 0x44.
    d_mepc = 32'h44;
    step(1'b0, 1'b1, OP_MRET, 32'h80, '0);
    #1 chk("mret_tgt", bus.int_addr_o, 32'h44);
    d_mie = 1'b1;
    idle(2);

    // Priority: irq1 and irq3 pulsed together.
    step(1'b0, 1'b0, OP_NOP, 32'h50, 4'b1010);
    step(1'b0, 1'b1, OP_NOP, 32'h54, '0);
    #1 chk("prio_irq1", bus.mcause_o, 32'h8000_0011);
    d_mie = 1'b0;
    idle(2);
    d_mepc = 32'h54;
    step(1'b0, 1'b1, OP_MRET, 32'h200, '0);
    d_mie = 1'b1;
    idle(1);
    step(1'b0, 1'b1, OP_NOP, 32'h54, '0);
    #1 chk("prio_irq3", bus.mcause_o, 32'h8000_0013);
    d_mie = 1'b0;
    idle(2);

    // Simultaneous ECALL and irq0: ECALL first, irq0 after MRET.
    d_mie = 1'b1;
    step(1'b0, 1'b1, OP_ECALL, 32'h60, 4'b0001);
    #1 chk("simul_ecall", bus.mcause_o, 32'd11);
    d_mie = 1'b0;
    idle(2);
    d_mepc = 32'h64;
    step(1'b0, 1'b1, OP_MRET, 32'h100, '0);
    d_mie = 1'b1;
    idle(1);
    step(1'b0, 1'b1, OP_NOP, 32'h64, '0);
    #1 chk("simul_irq0", bus.mcause_o, 32'h8000_0010);
    d_mie = 1'b0;
    idle(2);

    // mtvec mode 01 with irq2.
    d_mie = 1'b1; d_mtvec = 32'h101;
    step(1'b0, 1'b0, OP_NOP, 32'h70, 4'b0100);
    step(1'b0, 1'b0, OP_NOP, 32'h70, '0);
    d_mie = 1'b0;
    step(1'b0, 1'b0, OP_NOP, 32'h70, '0);
    #1 chk("vec_tgt", bus.int_addr_o, VEC ? 32'h148 : 32'h100);
    idle(1);

    // Reset asserted during SAVE abandons the trap.
    d_mie = 1'b1;
    step(1'b0, 1'b0, OP_NOP, 32'h90, 4'b0010);
    step(1'b0, 1'b0, OP_NOP, 32'h90, '0);
    step(1'b1, 1'b0, OP_NOP, 32'h90, '0);
    #1 chk("rst_save_redir", 32'(bus.interrupt_enable_o), 32'h0);
    chk("rst_save_we", 32'(bus.csr_we_o), 32'h0);
    idle(4);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      r_inst = (sel == 0) ? OP_ECALL : (sel == 1) ? OP_MRET : $urandom();
      r_irq = '0;
      for (int b = 0; b < NI; b++) r_irq[b] = ($urandom_range(0, 7) == 0);
      r_mtvec = $urandom();
      r_mtvec[1:0] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
      d_mtvec = r_mtvec;
      d_mask  = NI'($urandom());
      d_mie   = ($urandom_range(0, 3) != 0);
      d_mepc  = $urandom();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, r_inst,
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, r_irq);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Trap/interrupt controller for the single-issue RV32 core. It replaces the purely combinational ECALL/MRET redirect with a registered, multi-source machine.
- Handles synchronous traps (ECALL) and NUM_IRQ external interrupt lines with fixed priority, masking, and pending latches.
- Sequences CSR updates (mepc/mcause/MIE) and the PC redirect through a small FSM.
- Sits beside the decode stage. It drives the PC mux and the CSR file write port.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- RDATA_WIDTH, 32, instruction word width.
- NUM_IRQ, 4, number of external interrupt lines (1..16).
- ECALL_CAUSE, 11, mcause code written for ECALL.
- IRQ_CAUSE_BASE, 16, mcause code for irq 0; irq k uses IRQ_CAUSE_BASE+k.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- inst_i  in  RDATA_WIDTH  instruction in decode.
- inst_addr_i  in  ADDR_WIDTH  address of inst_i.
- inst_valid_i  in  1  inst_i is a real (non-bubble) instruction.
- irq_i  in  NUM_IRQ  level-sensitive interrupt requests.
- irq_mask_i  in  NUM_IRQ  per-line enable (mie bits) from CSR.
- mie_global_i  in  1  mstatus.MIE from CSR.
- mtvec_i  in  ADDR_WIDTH  trap base from CSR; bits[1:0] are ignored as address bits.
- mepc_i  in  ADDR_WIDTH  saved return PC from CSR.
- hold_o  out  1  stall fetch/decode.
- interrupt_enable_o  out  1  PC redirect strobe.
- int_addr_o  out  ADDR_WIDTH  redirect target.
- csr_we_o  out  1  write mepc/mcause and clear MIE this cycle.
- mepc_o  out  ADDR_WIDTH  value for mepc.
- mcause_o  out  32  value for mcause; bit31 = interrupt.
- mret_o  out  1  restore MIE from MPIE this cycle.

Behaviour:
- Reset (synchronous on rst_i):
  - All outputs go to 0, the pending register clears, and the FSM returns to IDLE.
  - This applies mid-operation too: a SAVE or JUMP in progress is abandoned and no CSR write or redirect is issued.
- Pending register:
  - Each cycle, pending <= pending | irq_i.
  - The bit of the line being taken clears on the SAVE cycle.
- Enabled set: pending & irq_mask_i, qualified by mie_global_i. The lowest index wins.
- FSM states: IDLE, SAVE, JUMP.
- IDLE transitions, in priority order:
  - inst_valid_i && inst_i==ECALL → SAVE, with cause=ECALL_CAUSE and epc=inst_addr_i.
  - inst_valid_i && inst_i==MRET → JUMP, with target=mepc_i and mret_o=1 in this IDLE cycle.
  - Enabled irq k → SAVE, with cause={1'b1, IRQ_CAUSE_BASE+k} and epc=inst_addr_i (instruction not executed).
  - Otherwise stay in IDLE.
- A simultaneous ECALL and irq takes the ECALL. The irq stays pending.
- SAVE (1 cycle):
  - csr_we_o=1, hold_o=1; mepc_o and mcause_o are held from the registered values.
  - Target is computed and registered. Next state is JUMP.
- JUMP (1 cycle):
  - interrupt_enable_o=1, hold_o=1, int_addr_o=registered target. Next state is IDLE.
  - inst_i and irq_i are not evaluated, but irq_i is still latched into pending.
- Trap target: {mtvec_i[ADDR_WIDTH-1:2], 2'b00}.
- Latencies:
  - Trap: detection to redirect is 2 cycles.
  - MRET: detection to redirect is 1 cycle.
- Interrupt arriving during SAVE/JUMP: it is latched and taken only once back in IDLE with mie_global_i=1. mie_global_i is normally 0 after SAVE until MRET.
- MRET followed by a pending enabled irq: the irq is taken in the first IDLE cycle after JUMP, provided the CSR has restored MIE.
- An instruction with inst_valid_i=0 never triggers ECALL/MRET.

Optional Feature:
- Macro: IRQ_VECTORED_EN.
- Defined:
  - If mtvec_i[1:0]==2'b01 and the cause is an interrupt, target = base + 4*(IRQ_CAUSE_BASE+k), wrapping modulo 2^ADDR_WIDTH.
  - ECALL always uses base.
- Undefined: mode bits are ignored and all traps use base.

Decomposition:
- Shared defines: ECALL and MRET encodings, ADDR_WIDTH, RDATA_WIDTH, FSM state encodings (IDLE=2'd0, SAVE=2'd1, JUMP=2'd2), and the mcause interrupt-bit position.
- One sub-module, irq_prio_enc: a combinational lowest-index priority encoder producing found and idx[$clog2(NUM_IRQ)-1:0].

Test Plan:
- Reset: rst_i held 3 cycles with irq_i=4'b1111 → all outputs 0 and pending clear; after release with irq_i=0, no trap.
- ECALL at inst_addr_i=0x40, mtvec_i=0x100:
  - Cycle+1: csr_we_o=1, mepc_o=0x40, mcause_o=11.
  - Cycle+2: interrupt_enable_o=1, int_addr_o=0x100.
- Priority: irq_i=4'b1010 pulsed for 1 cycle, mask=4'b1111, MIE=1 → mcause_o=0x80000011 (irq1); after MRET and MIE=1, irq3 is taken with mcause_o=0x80000013.
- Simultaneous ECALL and irq0 → ECALL taken first (mcause_o=11); irq0 remains pending and is taken after MRET.
- MRET with mepc_i=0x44 → mret_o=1 that cycle; next cycle interrupt_enable_o=1, int_addr_o=0x44.
- IRQ_VECTORED_EN with mtvec_i=0x101 and irq2 → int_addr_o=0x100+4*18=0x148; rst_i asserted during SAVE → no redirect and state returns to IDLE.
